// File: rtl/shift_load_pkg.sv
// -----------------------------------------------------------------------------
// shift_load_pkg
//   Shared types and constants for the serial program-load controller.
//   - state_e   : controller FSM states (PARITY only when parity mode is built)
//   - WORD_W_DEF: default word length (must match the external shift register)
//   - cnt_width : bit-count width for a given word length ($clog2(w+1))
//   Optional feature macro: SHIFT_LOAD_CTRL_PARITY_EN
// -----------------------------------------------------------------------------
package shift_load_pkg;

   localparam int WORD_W_DEF = 16;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_W = cnt_width(WORD_W_DEF);

`ifdef SHIFT_LOAD_CTRL_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_PARITY  = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;
`endif

endpackage

// File: rtl/pin_sync.sv
// -----------------------------------------------------------------------------
// pin_sync
//   STAGES-deep flop synchronizer for one asynchronous pin.
//   Ports:
//     clk     in  system clock
//     resetb  in  async active-low reset; all stages load RST_VAL
//     d_i     in  asynchronous pin
//     q_o     out synchronized pin (last stage)
// -----------------------------------------------------------------------------
module pin_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic resetb,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) ff_q <= {STAGES{RST_VAL}};
      else         ff_q <= {ff_q[STAGES-2:0], d_i};
   end

   assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/shift_load_ctrl.sv
// -----------------------------------------------------------------------------
// shift_load_ctrl
//   Frames WORD_W-bit words arriving on sck/mosi/cs_n, steps an external
//   serial-in shift register one bit per sck rise, and hands each completed
//   word to the CPU load port through a one-entry valid/ready buffer.
//   Optional feature macro: SHIFT_LOAD_CTRL_PARITY_EN (17th even-parity bit).
//   Ports:
//     clk, resetb          clock, async active-low reset
//     spi_sck_i/mosi_i/cs_n_i  async pins (sample on sck rise, MSB first)
//     clear_i              sync clear of sticky overrun_o
//     sr_in_o, sr_en_o     serial bit / shift pulse to the shift register
//     sr_word_i            shift register parallel output
//     word_o, word_valid_o, word_ready_i   holding buffer handshake
//     busy_o               frame in progress
//     overrun_o            sticky: word completed while buffer full
//     abort_o              pulse: cs_n released mid-word
//     parity_err_o         pulse: parity mismatch (0 without the macro)
// -----------------------------------------------------------------------------
module shift_load_ctrl
   import shift_load_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              spi_sck_i,
   input  logic              spi_mosi_i,
   input  logic              spi_cs_n_i,
   input  logic              clear_i,
   output logic              sr_in_o,
   output logic              sr_en_o,
   input  logic [WORD_W-1:0] sr_word_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic              busy_o,
   output logic              overrun_o,
   output logic              abort_o,
   output logic              parity_err_o
);

   localparam int             CW   = cnt_width(WORD_W);
   localparam logic [CW-1:0]  LAST = CW'(WORD_W);

   logic sck_s, mosi_s, cs_s;
   logic sck_prev_q, sck_rise;

   pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .resetb(resetb), .d_i(spi_sck_i), .q_o(sck_s));
   pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .resetb(resetb), .d_i(spi_mosi_i), .q_o(mosi_s));
   // cs_n idles high so reset must not look like a frame start
   pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .resetb(resetb), .d_i(spi_cs_n_i), .q_o(cs_s));

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) sck_prev_q <= 1'b0;
      else         sck_prev_q <= sck_s;
   end

   assign sck_rise = sck_s & ~sck_prev_q;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic              sr_in_q, sr_en_q, abort_q, overrun_q, word_valid_q;
   logic [WORD_W-1:0] word_q;
   logic              drop_par;

`ifdef SHIFT_LOAD_CTRL_PARITY_EN
   logic par_bad_q, perr_q;
   assign drop_par     = par_bad_q;
   assign parity_err_o = perr_q;
`else
   assign drop_par     = 1'b0;
   assign parity_err_o = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sr_in_q      <= 1'b0;
         sr_en_q      <= 1'b0;
         abort_q      <= 1'b0;
         overrun_q    <= 1'b0;
         word_valid_q <= 1'b0;
         word_q       <= '0;
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
         par_bad_q    <= 1'b0;
         perr_q       <= 1'b0;
`endif
      end else begin
         sr_en_q <= 1'b0;
         abort_q <= 1'b0;
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
         perr_q  <= 1'b0;
`endif
         if (word_valid_q && word_ready_i) word_valid_q <= 1'b0;
         // a set in CAPTURE below overrides this clear
         if (clear_i) overrun_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (!cs_s) state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // count==LAST holds for the cycle the last shift pulse is out,
               // so the register is settled one cycle later in CAPTURE
               if (cnt_q == LAST) begin
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
                  state_q <= ST_PARITY;
`else
                  state_q <= ST_CAPTURE;
`endif
               end else if (cs_s) begin
                  if (cnt_q != '0) abort_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else if (sck_rise) begin
                  sr_en_q <= 1'b1;
                  sr_in_q <= mosi_s;
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
            ST_PARITY: begin
               if (cs_s) begin
                  abort_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else if (sck_rise) begin
                  // even parity: data ones plus parity bit must be even
                  par_bad_q <= mosi_s ^ (^sr_word_i);
                  perr_q    <= mosi_s ^ (^sr_word_i);
                  state_q   <= ST_CAPTURE;
               end
            end
`endif
            ST_CAPTURE: begin
               cnt_q   <= '0;
               state_q <= cs_s ? ST_IDLE : ST_SHIFT;
               if (!drop_par) begin
                  if (!word_valid_q || word_ready_i) begin
                     word_q       <= sr_word_i;
                     word_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sr_in_o      = sr_in_q;
   assign sr_en_o      = sr_en_q;
   assign word_o       = word_q;
   assign word_valid_o = word_valid_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign overrun_o    = overrun_q;
   assign abort_o      = abort_q;

endmodule

// File: tb/tb_shift_load_ctrl.sv
module tb_shift_load_ctrl;

   localparam int W = 16;
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
   localparam int NB = W + 1, CAP_LAT = 3, VLD_LAT = 4;
`else
   localparam int NB = W, CAP_LAT = 4, VLD_LAT = 5;
`endif

   logic clk = 1'b0, resetb = 1'b0;
   logic sck = 1'b0, mosi = 1'b0, cs_n = 1'b1, clear = 1'b0, ready = 1'b0;
   logic [W-1:0] sr_model = '0;
   logic sr_in, sr_en, word_valid, busy, overrun, abort_p, perr;
   logic [W-1:0] word;

   shift_load_ctrl #(.WORD_W(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .resetb(resetb),
      .spi_sck_i(sck), .spi_mosi_i(mosi), .spi_cs_n_i(cs_n), .clear_i(clear),
      .sr_in_o(sr_in), .sr_en_o(sr_en), .sr_word_i(sr_model),
      .word_o(word), .word_valid_o(word_valid), .word_ready_i(ready),
      .busy_o(busy), .overrun_o(overrun), .abort_o(abort_p), .parity_err_o(perr));

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   int en_cnt = 0, abort_cnt = 0, perr_cnt = 0, vfall_cnt = 0;
   int last_en_cyc = 0, vrise_cyc = 0, vfall_cyc = 0;
   int wbits = 0, last_rise = 0, last_data_rise = 0;
   logic vld_prev = 1'b0;
   logic rnd_done = 1'b0;
   logic [31:0] acc_q[$];
   logic [31:0] exp_q[$];

   initial forever @(posedge clk) cyc <= cyc + 1;

   // external serial-in shift register (MSB first)
   initial forever @(posedge clk) if (sr_en) sr_model <= {sr_model[W-2:0], sr_in};

   initial forever begin
      @(negedge clk);
      if (resetb) begin
         if (sr_en) begin en_cnt++; last_en_cyc = cyc; end
         if (abort_p) abort_cnt++;
         if (perr) perr_cnt++;
         if (word_valid && !vld_prev) vrise_cyc = cyc;
         if (!word_valid && vld_prev) begin vfall_cnt++; vfall_cyc = cyc; end
         vld_prev = word_valid;
         if (word_valid && ready) acc_q.push_back(32'(word));
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_q.size()) return acc_q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sck_bit(input logic b, input int lo, input int hi);
      mosi = b;
      tick(lo);
      sck = 1'b1;
      last_rise = cyc;
      wbits++;
      tick(hi);
      sck = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic flip, input int lo, input int hi);
      wbits = 0;
      for (int i = W - 1; i >= 0; i--) sck_bit(w[i], lo, hi);
      last_data_rise = last_rise;
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
      sck_bit((^w) ^ flip, lo, hi);
`endif
   endtask

   task automatic frame_start();
      cs_n = 1'b0;
      tick(3);
   endtask

   task automatic frame_end();
      tick(4);
      cs_n = 1'b1;
      tick(6);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int base;
      // ---------------- reset
      tick(3);
      chk("rst_word_in", 32'(word), 0);
      chk("rst_flags_in", {sr_in, sr_en, word_valid, busy, overrun, abort_p, perr}, 0);
      resetb = 1'b1;
      tick(2);
      chk("rst_flags_out", {sr_in, sr_en, word_valid, busy, overrun, abort_p, perr}, 0);

      // ---------------- A: single word, ready high
      ready = 1'b1; en_cnt = 0; acc_q.delete();
      frame_start();
      send_word(16'hA5C3, 1'b0, 4, 4);
      frame_end();
      chk("A_en_cnt", en_cnt, 16);
      chk("A_en_time", last_en_cyc, last_data_rise + 3);
      chk("A_vrise", vrise_cyc, last_rise + VLD_LAT);
      chk("A_vfall", vfall_cyc, last_rise + VLD_LAT + 1);
      chk("A_acc_n", acc_q.size(), 1);
      chk("A_acc_word", acc_at(0), 32'hA5C3);
      chk("A_word_o", 32'(word), 32'hA5C3);
      chk("A_busy", busy, 0);

      // ---------------- B: two words, ready low -> overrun
      ready = 1'b0; acc_q.delete();
      frame_start();
      send_word(16'h1234, 1'b0, 4, 4);
      send_word(16'hBEEF, 1'b0, 4, 4);
      frame_end();
      chk("B_word_o", 32'(word), 32'h1234);
      chk("B_valid", word_valid, 1);
      chk("B_overrun", overrun, 1);
      clear = 1'b1; tick(1); clear = 1'b0;
      chk("B_clear", overrun, 0);
      ready = 1'b1; tick(1); ready = 1'b0; tick(1);
      chk("B_acc", acc_at(0), 32'h1234);
      chk("B_drained", word_valid, 0);

      // ---------------- C: accept exactly in capture cycle of 2nd word
      acc_q.delete();
      frame_start();
      send_word(16'h1234, 1'b0, 4, 4);
      base = vfall_cnt;
      wbits = 0;
      fork
         send_word(16'hBEEF, 1'b0, 4, 4);
         begin
            wait (wbits == NB);
            repeat (CAP_LAT) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
         end
      join
      frame_end();
      chk("C_word_o", 32'(word), 32'hBEEF);
      chk("C_valid", word_valid, 1);
      chk("C_no_gap", vfall_cnt, base);
      chk("C_overrun", overrun, 0);
      chk("C_acc0", acc_at(0), 32'h1234);
      ready = 1'b1; tick(1); ready = 1'b0; tick(1);
      chk("C_acc1", acc_at(1), 32'hBEEF);

      // ---------------- D: abort after 9 bits
      acc_q.delete(); abort_cnt = 0; ready = 1'b1;
      frame_start();
      for (int i = 0; i < 9; i++) sck_bit(1'($urandom), 4, 4);
      frame_end();
      chk("D_abort", abort_cnt, 1);
      chk("D_busy", busy, 0);
      chk("D_novalid", acc_q.size(), 0);
      frame_start();
      send_word(16'h00FF, 1'b0, 4, 4);
      frame_end();
      chk("D_word", acc_at(0), 32'h00FF);
      chk("D_abort_once", abort_cnt, 1);

      // ---------------- E: reset mid-frame
      acc_q.delete();
      frame_start();
      for (int i = 0; i < 12; i++) sck_bit(1'($urandom), 4, 4);
      resetb = 1'b0;
      #1;
      chk("E_rst_word", 32'(word), 0);
      chk("E_rst_flags", {sr_in, sr_en, word_valid, busy, overrun, abort_p, perr}, 0);
      cs_n = 1'b1; sck = 1'b0;
      tick(2);
      resetb = 1'b1;
      tick(2);
      frame_start();
      send_word(16'h8001, 1'b0, 4, 4);
      frame_end();
      chk("E_word", acc_at(0), 32'h8001);
      chk("E_n", acc_q.size(), 1);

`ifdef SHIFT_LOAD_CTRL_PARITY_EN
      // ---------------- F: parity
      acc_q.delete(); perr_cnt = 0;
      frame_start();
      send_word(16'h0003, 1'b0, 4, 4);
      frame_end();
      chk("F_good", acc_at(0), 32'h0003);
      chk("F_good_perr", perr_cnt, 0);
      frame_start();
      send_word(16'h0003, 1'b1, 4, 4);
      frame_end();
      chk("F_bad_perr", perr_cnt, 1);
      chk("F_bad_drop", acc_q.size(), 1);
      chk("F_bad_ovr", overrun, 0);
`endif

      // ---------------- random frames vs queue model
      begin
         int exp_abort = 0;
         acc_q.delete(); exp_q.delete(); abort_cnt = 0; perr_cnt = 0; rnd_done = 1'b0;
         fork
            begin
               for (int f = 0; f < 25; f++) begin
                  int nw, nb, lo, hi;
                  logic [W-1:0] w;
                  frame_start();
                  nw = $urandom_range(0, 3);
                  for (int k = 0; k < nw; k++) begin
                     w  = W'($urandom);
                     lo = $urandom_range(2, 5);
                     hi = $urandom_range(2, 5);
                     send_word(w, 1'b0, lo, hi);
                     exp_q.push_back(32'(w));
                  end
                  if ($urandom_range(0, 1) == 1) begin
                     nb = $urandom_range(0, 15);
                     for (int b = 0; b < nb; b++)
                        sck_bit(1'($urandom), $urandom_range(2, 5), $urandom_range(2, 5));
                     if (nb > 0) exp_abort++;
                  end
                  frame_end();
               end
               rnd_done = 1'b1;
            end
            begin
               int low_run = 0;
               while (!rnd_done) begin
                  if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
                     ready = 1'b1; low_run = 0;
                  end else begin
                     ready = 1'b0; low_run++;
                  end
                  tick(1);
               end
               ready = 1'b1;
               tick(4);
            end
         join
         chk("R_count", acc_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) chk($sformatf("R_word%0d", i), acc_at(i), exp_q[i]);
         chk("R_aborts", abort_cnt, exp_abort);
         chk("R_overrun", overrun, 0);
         chk("R_perr", perr_cnt, 0);
         chk("R_idle", {busy, word_valid}, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_load_ctrl.md
# shift_load_ctrl

Controller that sequences the 16-bit serial-in shift register to assemble program and data words arriving on an external SPI-style pin triplet (sck/mosi/cs_n). It synchronizes the pins, issues one shift-enable pulse per sampled bit, and counts bits to frame each word. Each completed word is captured into an output holding buffer and presented to the CPU load path with a valid/ready handshake. It sits between the chip pins and the CPU program-load port.

## Interface
- WORD_W, 16, word length; must equal the shift register width.
- SYNC_STAGES, 2, synchronizer depth on sck/mosi/cs_n; minimum 2.

- clk  in  1  system clock.
- resetb  in  1  reset; asynchronous, active-low.
- spi_sck_i  in  1  async serial clock; data sampled on its rising edge.
- spi_mosi_i  in  1  async serial data, MSB first.
- spi_cs_n_i  in  1  async frame select, active-low.
- clear_i  in  1  synchronous clear of sticky overrun_o.
- sr_in_o  out  1  serial data bit to shift register.
- sr_en_o  out  1  shift enable to shift register, one-cycle pulse per bit.
- sr_word_i  in  WORD_W  shift register parallel output.
- word_o  out  WORD_W  holding-buffer word.
- word_valid_o  out  1  word_o valid.
- word_ready_i  in  1  consumer accepts word_o when valid & ready.
- busy_o  out  1  frame in progress (state != IDLE).
- overrun_o  out  1  sticky: word completed while buffer full.
- abort_o  out  1  one-cycle pulse: cs_n deasserted mid-word.
- parity_err_o  out  1  one-cycle pulse: parity mismatch (constant 0 without the macro).

## Operation
- Pins pass through SYNC_STAGES flops; an edge register on synced sck gives a one-cycle rise pulse. clk must be ≥ 4× sck.
- FSM states: IDLE, SHIFT, PARITY (macro only), CAPTURE.
- IDLE: bit count = 0. Synced cs_n low → SHIFT.
- SHIFT: each sck rise → sr_en_o = 1, sr_in_o = synced mosi, count += 1. The 16th pulse → PARITY (macro) or CAPTURE.
- CAPTURE (one cycle): sr_word_i is loaded into the buffer, the count is cleared, then → SHIFT if cs_n is low, else IDLE. Back-to-back words within one frame are supported.
- Buffer full (word_valid_o = 1, no accept this cycle) at CAPTURE → the new word is dropped, overrun_o is set, and buffer contents are unchanged.
- Accept and CAPTURE in the same cycle → the new word is loaded, word_valid_o stays 1, no overrun.
- cs_n high while count ∈ 1..15 (or in PARITY) → abort_o pulse, count = 0, → IDLE. No word is produced, and the buffer is unaffected. The shift register is not cleared; stale bits are shifted out by the next 16 bits.
- cs_n high with count = 0 → IDLE silently.
- sck rises while in CAPTURE are never lost: the sck high time of ≥ 2 clk guarantees the edge falls in SHIFT.
- overrun_o is cleared by clear_i. If set and clear coincide, set wins.

## Timing
- Reset values: sr_in_o 0, sr_en_o 0, word_o 0, word_valid_o 0, busy_o 0, overrun_o 0, abort_o 0, parity_err_o 0. FSM in IDLE with count 0.
- Reset mid-frame: immediate return to reset values, and the partial word is discarded.
- sr_en_o is asserted in the cycle after the sck rise is visible at the last sync stage (pin-to-enable latency of SYNC_STAGES+1 clk).
- The 16th sr_en_o falls in cycle T. CAPTURE occurs in T+1, and word_valid_o = 1 from T+2.
- Parity mode: the parity-bit rise pulse falls in cycle P. Capture is in P+1, and word_valid_o rises in P+2.
- word_valid_o falls in the cycle after an accept unless a new word is captured in that same cycle.

## Configuration
- SHIFT_LOAD_CTRL_PARITY_EN defined:
  - A 17th bit (even parity over the 16 bits) follows each word. It is sampled in PARITY and is not shifted into the register.
  - Mismatch → parity_err_o pulse in the capture cycle and the word is dropped; overrun_o is not affected.
  - Match → normal capture.
- SHIFT_LOAD_CTRL_PARITY_EN undefined: PARITY state is absent and parity_err_o is tied 0.

## Structure
- Package shift_load_pkg: the FSM state enum, the WORD_W default, and the bit-count width constant ($clog2(WORD_W+1)).
- One sub-module, pin_sync: a SYNC_STAGES-deep synchronizer with async active-low reset to 0 (cs_n stage resets to 1). It is instantiated for each of the three pins.
- The shift register stays external. The controller only drives sr_in_o/sr_en_o and reads sr_word_i.

## Test plan
- Reset, then one frame shifting 0xA5C3 with word_ready_i = 1 → exactly 16 sr_en_o pulses; word_o = 0xA5C3 and word_valid_o high at T+2, dropping after accept.
- Two back-to-back words 0x1234, 0xBEEF in one frame, ready held 0 until both complete → word_o = 0x1234 and overrun_o = 1. Then clear_i → overrun_o = 0.
- ready pulsed in the exact CAPTURE cycle of the second word → word_o = 0xBEEF, word_valid_o continuously 1, overrun_o = 0.
- cs_n raised after 9 bits → abort_o single pulse, busy_o = 0, no valid. A following full frame with 0x00FF yields 0x00FF.
- resetb asserted after 12 bits → all outputs return to reset values immediately. The next frame with 0x8001 → word_o = 0x8001.
- With SHIFT_LOAD_CTRL_PARITY_EN: 0x0003 + parity 0 → word valid; 0x0003 + parity 1 → parity_err_o pulse, no valid.
